imem_boot_loader: RTL and testbench

- Sequences the instruction BRAM write port (w_addr/w_dat/w_enb) and holds the core in reset while a program image is loaded.
- Consumes a framed little-endian byte stream, e.g. from a UART receiver, over a valid/ready handshake.
- Assembles 32-bit words, writes them to consecutive word addresses, then releases the core to fetch from BASE_ADDR.

---
 rtl/imem_boot_loader.sv | 130 +++++++++++++
 tb/tb_imem_boot_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed little-endian byte stream into 32-bit words,
// writes them to the instruction BRAM and keeps the core in reset until the image is in place.
module imem_boot_loader #(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            MEM_DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter bit                     BOOT_ON_RESET   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [31:0]           i_w_dat,
  output logic                  i_w_enb,
  output logic                  core_rst,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    S_RUN, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam state_t RST_STATE = BOOT_ON_RESET ? S_HDR0 : S_RUN;

  state_t                r_state, w_next;
  logic [15:0]           r_len;
  logic [15:0]           r_word_cnt;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic        w_accept, w_enb, w_busy, w_done, w_err, w_hold;
  logic        w_xfer, w_len_over, w_last_word;
  logic [15:0] w_len_full;

  assign w_xfer      = byte_valid & w_accept;
  assign w_len_full  = {byte_data, r_len[7:0]};
  assign w_len_over  = 32'(w_len_full) > 32'(MEM_DEPTH_WORDS);
  assign w_last_word = (r_word_cnt == r_len - 16'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RST_STATE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (load_req) w_next = S_HDR0;
      S_HDR0:  if (w_xfer) w_next = S_HDR1;
      S_HDR1:  if (w_xfer) begin
                 if (w_len_over)            w_next = S_ERR;
                 else if (w_len_full == '0) w_next = S_DONE;
                 else                       w_next = S_DATA;
               end
      S_DATA:  if (w_xfer && r_byte_idx == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
      S_DONE:  w_next = S_RUN;
      S_ERR:   if (load_req) w_next = S_HDR0;
      default: w_next = RST_STATE;
    endcase
  end

  // Output decode
  always_comb begin
    w_accept = 1'b0;
    w_enb    = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_hold   = 1'b1;
    unique case (r_state)
      S_RUN:                  w_hold = 1'b0;
      S_HDR0, S_HDR1, S_DATA: begin w_accept = 1'b1; w_busy = 1'b1; end
      S_WRITE:                begin w_enb = 1'b1; w_busy = 1'b1; end
      S_DONE:                 w_done = 1'b1;
      S_ERR:                  begin w_accept = 1'b1; w_err = 1'b1; end
      default:                ;
    endcase
  end

  // Strobes are masked while rst is high so the reset values are visible during reset itself.
  assign byte_ready = w_accept & ~rst;
  assign i_w_enb    = w_enb    & ~rst;
  assign load_busy  = w_busy   & ~rst;
  assign load_done  = w_done   & ~rst;
  assign load_err   = w_err    & ~rst;
  assign core_rst   = w_hold   |  rst;
  assign i_w_addr   = r_addr;
  assign i_w_dat    = r_word;

  // Header capture, word assembly and write addressing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_addr     <= BASE_ADDR;
    end else begin
      unique case (r_state)
        S_HDR0: if (w_xfer) r_len[7:0] <= byte_data;
        S_HDR1: if (w_xfer) begin
                  r_len[15:8] <= byte_data;
                  r_byte_idx  <= '0;
                  r_word_cnt  <= '0;
                  r_addr      <= BASE_ADDR;
                end
        S_DATA: if (w_xfer) begin
                  r_word[8*r_byte_idx +: 8] <= byte_data;
                  r_byte_idx                <= r_byte_idx + 2'd1;
                end
        // The address stops on the final word so it never points past the loaded image.
        S_WRITE: begin
                  r_word_cnt <= r_word_cnt + 16'd1;
                  if (!w_last_word) r_addr <= r_addr + ADDR_WIDTH'(4);
                end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a boot-on-reset instance (depth 4, base 0) and a
// run-after-reset instance (depth 16, base 0x100), exercised one at a time.
module tb_imem_boot_loader;

  localparam int          A_DEPTH = 4;
  localparam logic [31:0] A_BASE  = 32'h0;
  localparam int          B_DEPTH = 16;
  localparam logic [31:0] B_BASE  = 32'h100;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];
  typedef struct {
    logic        r, l, v;
    logic [7:0]  d;
    logic [5:0]  f;     // {ready, enb, core_rst, done, err, busy}
    logic [31:0] a, w;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, lr = 1'b0, vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       sel = 1'b0;

  logic        a_rdy, a_enb, a_crst, a_busy, a_done, a_err;
  logic        b_rdy, b_enb, b_crst, b_busy, b_done, b_err;
  logic [31:0] a_addr, a_dat, b_addr, b_dat;

  imem_boot_loader #(.ADDR_WIDTH(32), .MEM_DEPTH_WORDS(A_DEPTH), .BASE_ADDR(A_BASE),
                     .BOOT_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst(rst), .load_req(lr & ~sel), .byte_valid(vld & ~sel), .byte_data(dat),
    .byte_ready(a_rdy), .i_w_addr(a_addr), .i_w_dat(a_dat), .i_w_enb(a_enb),
    .core_rst(a_crst), .load_busy(a_busy), .load_done(a_done), .load_err(a_err));

  imem_boot_loader #(.ADDR_WIDTH(32), .MEM_DEPTH_WORDS(B_DEPTH), .BASE_ADDR(B_BASE),
                     .BOOT_ON_RESET(1'b0)) u_b (
    .clk(clk), .rst(rst), .load_req(lr & sel), .byte_valid(vld & sel), .byte_data(dat),
    .byte_ready(b_rdy), .i_w_addr(b_addr), .i_w_dat(b_dat), .i_w_enb(b_enb),
    .core_rst(b_crst), .load_busy(b_busy), .load_done(b_done), .load_err(b_err));

  logic        w_rdy, w_enb, w_crst, w_busy, w_done, w_err;
  logic [31:0] w_addr, w_dat;
  assign w_rdy  = sel ? b_rdy  : a_rdy;
  assign w_enb  = sel ? b_enb  : a_enb;
  assign w_crst = sel ? b_crst : a_crst;
  assign w_busy = sel ? b_busy : a_busy;
  assign w_done = sel ? b_done : a_done;
  assign w_err  = sel ? b_err  : a_err;
  assign w_addr = sel ? b_addr : a_addr;
  assign w_dat  = sel ? b_dat  : a_dat;

  int  n_vec = 0, n_err = 0, n_overlap = 0, done_cnt = 0;
  int  st = 0;   // what the bench expects: 0 header wait, 1 running, 2 error
  logic [63:0] act_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (a_enb && a_rdy) n_overlap++;
      if (b_enb && b_rdy) n_overlap++;
      if (w_enb) act_q.push_back({w_addr, w_dat});
      if (w_done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t V(input logic r, input logic l, input logic v, input logic [7:0] d,
                             input logic [5:0] f, input logic [31:0] a, input logic [31:0] w);
    vec_t t;
    t.r = r; t.l = l; t.v = v; t.d = d; t.f = f; t.a = a; t.w = w;
    return t;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic gap);
    int c = 0;
    if (gap) begin vld = 1'b0; @(negedge clk); end
    vld = 1'b1; dat = b; #1;
    while (!w_rdy && c < 50) begin @(negedge clk); #1; c++; end
    if (!w_rdy) begin
      n_vec++; n_err++;
      $display("FAIL rdy_timeout: got ready=%0b expected 1 for byte 0x%02h", w_rdy, b);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic start_load();
    if (st != 0) begin
      lr = 1'b1; @(negedge clk); lr = 1'b0; #1;
      chk("req_to_hdr", {w_rdy, w_busy, w_crst, w_err}, 4'b1110);
      st = 0;
    end
  endtask

  // mode: 0 back-to-back, 1 idle cycle before every byte, 2 random idles
  task automatic xfer(input bq_t bs, input wq_t exq, input int mode, input logic is_err,
                      input int lr_at);
    int c;
    start_load();
    act_q.delete(); done_cnt = 0;
    foreach (bs[i]) begin
      send_byte(bs[i], (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1));
      if (i == lr_at) begin lr = 1'b1; @(negedge clk); lr = 1'b0; end
    end
    if (is_err) begin
      for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0);
      #1 chk("err_state", {w_err, w_crst, w_busy, w_rdy}, 4'b1101);
      chk("err_done_cnt", done_cnt, 0);
      st = 2;
    end else begin
      c = 0;
      while (done_cnt == 0 && c < 40) begin @(negedge clk); c++; end
      @(negedge clk); #1;
      chk("done_once", done_cnt, 1);
      chk("core_released", {w_crst, w_busy, w_rdy, w_err}, 4'b0000);
      st = 1;
    end
    chk("n_writes", act_q.size(), exq.size());
    foreach (exq[i]) if (i < act_q.size()) chk($sformatf("write%0d", i), act_q[i], exq[i]);
  endtask

  task automatic rand_frame(input int depth, input logic [31:0] base, input int force_n);
    bq_t bs; wq_t ex; int n; int la; logic [31:0] w;
    n = (force_n >= 0) ? force_n : int'($urandom_range(0, depth + 2));
    bs.push_back(8'(n)); bs.push_back(8'(n >> 8));
    if (n <= depth)
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        ex.push_back({base + 32'(4 * i), w});
        for (int k = 0; k < 4; k++) bs.push_back(w[8*k +: 8]);
      end
    la = (n <= depth && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, bs.size() - 1)) : -1;
    xfer(bs, ex, 2, n > depth, la);
  endtask

  initial begin
    vec_t tv[$];
    bq_t  bs;
    wq_t  ex;

    // Program load, zero-length frame, oversize frame and recovery on instance A
    tv.push_back(V(1'b1, 1'b0, 1'b0, 8'h00, 6'b001000, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h02, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h13, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h05, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h10, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b011001, 32'h0, 32'h00100513));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h93, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h05, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h20, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b011001, 32'h4, 32'h00200593));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b001100, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b000000, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b1, 1'b0, 8'h00, 6'b000000, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b001100, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b000000, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b1, 1'b0, 8'h00, 6'b000000, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h05, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'hAA, 6'b101010, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b1, 8'hBB, 6'b101010, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b1, 1'b0, 8'h00, 6'b101010, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b1, 1'b0, 8'h00, 6'b101001, 32'h0, 32'h0));
    tv.push_back(V(1'b0, 1'b0, 1'b0, 8'h00, 6'b101001, 32'h0, 32'h0));

    repeat (2) @(negedge clk);
    foreach (tv[i]) begin
      rst = tv[i].r; lr = tv[i].l; vld = tv[i].v; dat = tv[i].d; #1;
      chk($sformatf("tv%0d_flags", i), {w_rdy, w_enb, w_crst, w_done, w_err, w_busy}, tv[i].f);
      if (tv[i].r || tv[i].f[4]) begin
        chk($sformatf("tv%0d_addr", i), w_addr, tv[i].a);
        chk($sformatf("tv%0d_dat", i), w_dat, tv[i].w);
      end
      @(negedge clk);
    end
    lr = 1'b0; vld = 1'b0; st = 0;

    // Gapped single-word frame
    bs = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ex = '{{A_BASE, 32'hEFBEADDE}};
    xfer(bs, ex, 1, 1'b0, -1);

    // Reset in the middle of the second word
    start_load();
    act_q.delete(); done_cnt = 0;
    bs = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (bs[i]) send_byte(bs[i], 1'b0);
    rst = 1'b1; @(negedge clk); #1;
    chk("midrst_flags", {w_rdy, w_enb, w_done, w_err, w_busy, w_crst}, 6'b000001);
    chk("midrst_addr", w_addr, A_BASE);
    chk("midrst_dat", w_dat, 32'h0);
    rst = 1'b0; @(negedge clk); #1;
    chk("midrst_hdr0", {w_rdy, w_busy, w_crst}, 3'b111);
    chk("midrst_nwr", act_q.size(), 1);
    if (act_q.size() > 0) chk("midrst_wr0", act_q[0], {A_BASE, 32'h44332211});
    st = 0;
    bs = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    ex = '{{A_BASE, 32'hDDCCBBAA}};
    xfer(bs, ex, 0, 1'b0, -1);

    // Randomized frames on A, including exactly-full and one-over lengths
    rand_frame(A_DEPTH, A_BASE, A_DEPTH);
    rand_frame(A_DEPTH, A_BASE, A_DEPTH + 1);
    rand_frame(A_DEPTH, A_BASE, 0);
    for (int it = 0; it < 10; it++) rand_frame(A_DEPTH, A_BASE, -1);

    // Instance B: core runs after reset, load on request, load_req in DATA ignored
    sel = 1'b1;
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; @(negedge clk); #1;
    chk("b_reset", {w_crst, w_rdy, w_busy, w_err, w_done, w_enb}, 6'b000000);
    chk("b_reset_addr", w_addr, B_BASE);
    st = 1;
    bs = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    ex = '{{B_BASE, 32'h04030201}, {B_BASE + 32'h4, 32'h08070605}};
    xfer(bs, ex, 0, 1'b0, 3);
    rand_frame(B_DEPTH, B_BASE, B_DEPTH);
    rand_frame(B_DEPTH, B_BASE, B_DEPTH + 1);
    for (int it = 0; it < 8; it++) rand_frame(B_DEPTH, B_BASE, -1);

    chk("enb_ready_overlap", n_overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
